mux2_arbiter: RTL and testbench
===============================

MUX2_ARBITER -- requirements
Module: mux2_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width of each requester and of the output.
REQ-002 SHALL have parameter MAX_BEATS, default 16: maximum beats per locked packet before forced release; legal range 1..255.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have ports req0 / req1, input, 1: requester 0/1 has a valid beat.
REQ-006 SHALL have ports data0 / data1, input, WIDTH: beat payload for requester 0/1.
REQ-007 SHALL have ports last0 / last1, input, 1: the beat is the final beat of the packet.
REQ-008 SHALL have ports ready0 / ready1, output, 1: the beat of requester 0/1 is accepted this cycle.
REQ-009 SHALL have ports grant0 / grant1, output, 1: requester 0/1 owns the shared output; one-hot or zero.
REQ-010 SHALL have ports out_valid / out_data / out_last, output, 1 / WIDTH / 1: the muxed beat to the consumer.
REQ-011 SHALL have port out_ready, input, 1: the consumer accepts out_data this cycle.
REQ-012 SHALL have port overrun, output, 1: one-cycle pulse when a packet is force-released at MAX_BEATS.

Function
REQ-013 FSM states SHALL be IDLE, BUSY0 and BUSY1; grant0 = (state==BUSY0), grant1 = (state==BUSY1).
REQ-014 Round-robin pointer prio (1 bit) SHALL name the favoured requester when both request.
REQ-015 IDLE: req0 only -> BUSY0; req1 only -> BUSY1; both -> BUSY<prio>; none -> stay; each move takes 1 cycle.
REQ-016 In BUSYx: out_valid = reqx, out_data = datax, out_last = lastx; out_data and out_last SHALL be 0 when out_valid=0.
REQ-017 readyx SHALL equal grantx & reqx & out_ready; readyy for the non-granted requester SHALL be 0.
REQ-018 A beat transfers when out_valid & out_ready; beat counter cnt (8 bit) SHALL increment per transfer and clear on release.
REQ-019 Release SHALL occur on a transfer with lastx=1, or on a transfer bringing cnt to MAX_BEATS with lastx=0; the second case pulses overrun for that cycle.
REQ-020 On release from BUSYx: prio <- ~x; next state BUSYy if reqy=1 in that cycle, else IDLE (zero-bubble hand-over).
REQ-021 If reqx drops inside BUSYx, the lock SHALL hold, out_valid=0, and cnt is unchanged.
REQ-022 out_ready=0 SHALL stall: state, cnt and prio are unchanged, and the beat stays presented.
REQ-023 Latency SHALL be 1 cycle from the first req in IDLE to out_valid, and 0 cycles from a BUSYx input to the output.

Reset
REQ-024 While rst=1: state=IDLE, prio=0, cnt=0, and grant0/1, ready0/1, out_valid, out_data, out_last and overrun are all 0.
REQ-025 Reset mid-packet SHALL drop the lock immediately; after deassertion arbitration restarts from IDLE with prio=0.

Structure
REQ-026 Package mux2_arbiter_pkg SHALL hold the state enum (IDLE=2'd0, BUSY0=2'd1, BUSY1=2'd2) and the default WIDTH/MAX_BEATS constants.
REQ-027 The data path SHALL instantiate WIDTH copies of the existing mux2_1 cell (sel=grant1), gated to 0 when out_valid=0.
REQ-028 FSM, pointer and counter SHALL be a single clocked block; all outputs except the state-derived grants SHALL be combinational from state and inputs.

Verification
REQ-029 Reset then req0=1, data0=8'hA5, last0=1, out_ready=1 -> next cycle grant0=1, out_data=A5, ready0=1; following cycle IDLE, prio=1.
REQ-030 req0 and req1 both held with 1-beat packets (last=1), out_ready=1 -> grants alternate 0,1,0,1 with no idle cycle between them.
REQ-031 Requester 0 sends a 3-beat packet while req1=1 throughout -> grant1 stays 0 until the beat with last0=1; grant1=1 on the next cycle.
REQ-032 MAX_BEATS=4, req0 streaming with last0=0 -> overrun pulses on the 4th transfer, then grant passes to req1 or IDLE.
REQ-033 out_ready=0 for 3 cycles mid-packet -> out_data stable, ready0=0, cnt unchanged; the transfer resumes when out_ready=1.
REQ-034 rst asserted mid-packet in BUSY1 -> all outputs 0 asynchronously; after release, simultaneous req0/req1 grants req0 first.

Source files
------------

// File: rtl/mux2_arbiter_pkg.sv
// Shared types and default sizing for the two-requester packet arbiter.
package mux2_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH     = 8;
    localparam int DEFAULT_MAX_BEATS = 16;

endpackage

// File: rtl/mux2_1.sv
// Single-bit 2:1 multiplexer cell; sel=1 picks b.
module mux2_1 (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin arbiter that locks the shared output to one requester for a
// whole packet, with a forced release after MAX_BEATS beats.
module mux2_arbiter
    import mux2_arbiter_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MAX_BEATS = DEFAULT_MAX_BEATS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic             last0,
    input  logic             last1,
    output logic             ready0,
    output logic             ready1,
    output logic             grant0,
    output logic             grant1,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             overrun
);

    localparam logic [7:0] MAX_CNT = 8'(MAX_BEATS);

    state_t     state, state_n;
    logic       prio, prio_n;
    logic [7:0] cnt, cnt_n;
    logic [7:0] cnt_inc;
    logic [WIDTH-1:0] mux_data;
    logic       xfer;
    logic       at_max;
    logic       release_pkt;

    assign grant0 = (state == BUSY0);
    assign grant1 = (state == BUSY1);

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_mux
            mux2_1 u_mux (
                .a  (data0[i]),
                .b  (data1[i]),
                .sel(grant1),
                .y  (mux_data[i])
            );
        end
    endgenerate

    // Payload and handshake are purely combinational so a locked beat passes
    // straight through with no added latency.
    always_comb begin
        out_valid   = (grant0 & req0) | (grant1 & req1);
        out_data    = out_valid ? mux_data : '0;
        out_last    = out_valid & (grant1 ? last1 : last0);
        ready0      = grant0 & req0 & out_ready;
        ready1      = grant1 & req1 & out_ready;
        xfer        = out_valid & out_ready;
        cnt_inc     = cnt + 8'd1;
        at_max      = (cnt_inc == MAX_CNT);
        release_pkt = xfer & (out_last | at_max);
        overrun     = xfer & ~out_last & at_max;
    end

    always_comb begin
        state_n = state;
        prio_n  = prio;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (req0 && req1) state_n = prio ? BUSY1 : BUSY0;
                else if (req0)    state_n = BUSY0;
                else if (req1)    state_n = BUSY1;
            end
            BUSY0: begin
                if (release_pkt) begin
                    prio_n  = 1'b1;
                    cnt_n   = '0;
                    state_n = req1 ? BUSY1 : IDLE;
                end else if (xfer) begin
                    cnt_n = cnt_inc;
                end
            end
            BUSY1: begin
                if (release_pkt) begin
                    prio_n  = 1'b0;
                    cnt_n   = '0;
                    state_n = req0 ? BUSY0 : IDLE;
                end else if (xfer) begin
                    cnt_n = cnt_inc;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            prio  <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            prio  <= prio_n;
            cnt   <= cnt_n;
        end
    end

endmodule

// File: tb/tb_mux2_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a
// packet-level reference model of the arbiter.
module tb_mux2_arbiter;

    localparam int W    = 8;
    localparam int MAXB = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0, req1, last0, last1, out_ready;
    logic [W-1:0] data0, data1;
    logic         ready0, ready1, grant0, grant1;
    logic         out_valid, out_last, overrun;
    logic [W-1:0] out_data;

    int total = 0;
    int bad   = 0;

    mux2_arbiter #(.WIDTH(W), .MAX_BEATS(MAXB)) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .req1     (req1),
        .data0    (data0),
        .data1    (data1),
        .last0    (last0),
        .last1    (last1),
        .ready0   (ready0),
        .ready1   (ready1),
        .grant0   (grant0),
        .grant1   (grant1),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_last (out_last),
        .out_ready(out_ready),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the output, whose turn it is, beats taken so far.
    int owner = -1;
    int rr    = 0;
    int beats = 0;

    always @(negedge clk) begin
        logic rq[2];
        logic lt[2];
        logic [W-1:0] dt[2];
        logic e_g[2], e_r[2];
        logic e_v, e_l, e_o, xf, fin;
        logic [W-1:0] e_d;
        rq[0] = req0; rq[1] = req1;
        lt[0] = last0; lt[1] = last1;
        dt[0] = data0; dt[1] = data1;
        e_g[0] = 0; e_g[1] = 0; e_r[0] = 0; e_r[1] = 0;
        e_v = 0; e_l = 0; e_o = 0; e_d = '0; xf = 0; fin = 0;
        if (rst) begin
            owner = -1; rr = 0; beats = 0;
        end else if (owner >= 0) begin
            e_g[owner] = 1;
            e_v = rq[owner];
            e_d = e_v ? dt[owner] : '0;
            e_l = e_v & lt[owner];
            e_r[owner] = e_v & out_ready;
            xf  = e_v & out_ready;
            fin = xf && (lt[owner] || beats + 1 == MAXB);
            e_o = xf && !lt[owner] && (beats + 1 == MAXB);
        end
        checkOutput("grant0", 32'(grant0), 32'(e_g[0]));
        checkOutput("grant1", 32'(grant1), 32'(e_g[1]));
        checkOutput("ready0", 32'(ready0), 32'(e_r[0]));
        checkOutput("ready1", 32'(ready1), 32'(e_r[1]));
        checkOutput("out_valid", 32'(out_valid), 32'(e_v));
        checkOutput("out_data", 32'(out_data), 32'(e_d));
        checkOutput("out_last", 32'(out_last), 32'(e_l));
        checkOutput("overrun", 32'(overrun), 32'(e_o));
        if (!rst) begin
            if (owner < 0) begin
                if (rq[0] && rq[1]) owner = rr;
                else if (rq[0])     owner = 0;
                else if (rq[1])     owner = 1;
                beats = 0;
            end else if (fin) begin
                rr    = 1 - owner;
                beats = 0;
                owner = rq[1 - owner] ? 1 - owner : -1;
            end else if (xf) begin
                beats++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r0, input logic r1, input logic l0, input logic l1,
                                 input logic [W-1:0] d0, input logic [W-1:0] d1, input logic ordy);
        req0 = r0; req1 = r1; last0 = l0; last1 = l1;
        data0 = d0; data1 = d1; out_ready = ordy;
    endtask

    task automatic doReset();
        applyStimulus(0, 0, 0, 0, '0, '0, 0);
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, '0, '0, 0);
        cyc();
        @(negedge clk);
        checkOutput("reset_grant0", 32'(grant0), 0);
        checkOutput("reset_valid", 32'(out_valid), 0);

        // Single one-beat packet, then the pointer favours requester 1.
        doReset();
        applyStimulus(1, 0, 1, 0, 8'hA5, 8'h00, 1);
        @(negedge clk);
        checkOutput("idle_grant0", 32'(grant0), 0);
        cyc();
        @(negedge clk);
        checkOutput("t1_grant0", 32'(grant0), 1);
        checkOutput("t1_data", 32'(out_data), 32'h A5);
        checkOutput("t1_ready0", 32'(ready0), 1);
        cyc();
        applyStimulus(0, 0, 0, 0, '0, '0, 1);
        @(negedge clk);
        checkOutput("t1_idle_g0", 32'(grant0), 0);
        checkOutput("t1_idle_g1", 32'(grant1), 0);
        applyStimulus(1, 1, 1, 1, 8'h11, 8'h3C, 1);
        cyc();
        @(negedge clk);
        checkOutput("t1_prio_g1", 32'(grant1), 1);
        checkOutput("t1_prio_data", 32'(out_data), 32'h3C);
        cyc();
        applyStimulus(0, 0, 0, 0, '0, '0, 0);

        // Alternating one-beat packets with zero-bubble hand-over.
        doReset();
        applyStimulus(1, 1, 1, 1, 8'h01, 8'h02, 1);
        cyc();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("alt_grant0", 32'(grant0), 32'(i % 2 == 0));
            checkOutput("alt_grant1", 32'(grant1), 32'(i % 2 == 1));
            cyc();
        end
        applyStimulus(0, 0, 0, 0, '0, '0, 0);

        // Three-beat packet holds the lock against a waiting requester.
        doReset();
        applyStimulus(1, 1, 0, 1, 8'h40, 8'h80, 1);
        cyc();
        for (int i = 0; i < 3; i++) begin
            last0 = (i == 2);
            data0 = 8'(8'h40 + i);
            @(negedge clk);
            checkOutput("lock_grant0", 32'(grant0), 1);
            checkOutput("lock_grant1", 32'(grant1), 0);
            cyc();
        end
        @(negedge clk);
        checkOutput("lock_handover", 32'(grant1), 1);
        cyc();
        applyStimulus(0, 0, 0, 0, '0, '0, 0);

        // Forced release on the MAX_BEATS-th transfer.
        doReset();
        applyStimulus(1, 0, 0, 0, 8'h77, 8'h00, 1);
        cyc();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("ovr_pulse", 32'(overrun), 32'(i == 3));
            cyc();
        end
        req0 = 1'b0;
        @(negedge clk);
        checkOutput("ovr_idle_g0", 32'(grant0), 0);
        checkOutput("ovr_idle_g1", 32'(grant1), 0);
        cyc();

        // Consumer stall mid-packet.
        doReset();
        applyStimulus(1, 0, 0, 0, 8'h5A, 8'h00, 1);
        cyc();
        @(negedge clk);
        checkOutput("stall_pre_ready", 32'(ready0), 1);
        cyc();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("stall_ready0", 32'(ready0), 0);
            checkOutput("stall_data", 32'(out_data), 32'h5A);
            checkOutput("stall_overrun", 32'(overrun), 0);
            cyc();
        end
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("stall_resume", 32'(ready0), 1);
        cyc();
        @(negedge clk);
        checkOutput("stall_cnt_kept", 32'(overrun), 0);
        cyc();
        applyStimulus(0, 0, 0, 0, '0, '0, 0);

        // Asynchronous reset while requester 1 holds the lock.
        doReset();
        applyStimulus(0, 1, 0, 0, 8'h00, 8'hC3, 1);
        cyc();
        @(negedge clk);
        checkOutput("ar_grant1", 32'(grant1), 1);
        cyc();
        rst = 1'b1;
        #1;
        checkOutput("ar_async_g1", 32'(grant1), 0);
        checkOutput("ar_async_valid", 32'(out_valid), 0);
        checkOutput("ar_async_data", 32'(out_data), 0);
        cyc();
        rst = 1'b0;
        applyStimulus(1, 1, 1, 1, 8'h0F, 8'hF0, 1);
        cyc();
        @(negedge clk);
        checkOutput("ar_first_g0", 32'(grant0), 1);
        cyc();
        applyStimulus(0, 0, 0, 0, '0, '0, 0);

        // Random traffic against the reference model.
        doReset();
        for (int n = 0; n < 1500; n++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                          W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                          $urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 199) == 0);
            cyc();
        end
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, '0, '0, 0);
        cyc();
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
